audio_pdm_tx: RTL and testbench
===============================

Name: audio_pdm_tx

Overview:
- Playback-side counterpart of the microphone PDM decimator: the transmit end of the same PDM audio link.
- Accepts 8-bit signed samples at ~12 kHz from the recorder playback path over a valid/ready handshake and buffers them in a small FIFO.
- Emits a 1-bit first-order sigma-delta PDM stream at the mic-clock step rate (98.3 MHz / 32 = 3.072 MHz) to drive the audio output pin through an RC filter.
- Sits in the clk_m domain beside the recorder.

Parameters:
- SAMPLE_W, 8, sample width, two's complement.
- FIFO_DEPTH, 8, sample FIFO entries; power of two, ≥2.
- STEP_PERIOD, 32, clk_in cycles per PDM step.
- STEPS_PER_SAMPLE, 256, PDM steps per audio sample.

Ports:
- clk_in  input  1  system clock (clk_m, 98.3 MHz).
- rst_in  input  1  asynchronous, active-high reset.
- enable_in  input  1  run modulator; low = idle.
- sample_in  input  SAMPLE_W  signed audio sample.
- sample_valid_in  input  1  sample_in valid.
- sample_ready_out  output  1  FIFO can accept.
- clear_underrun_in  input  1  clears sticky underrun flag.
- pdm_out  output  1  PDM bit.
- pdm_step_out  output  1  one-cycle pulse when pdm_out updates.
- underrun_out  output  1  sticky: FIFO empty at a sample boundary.
- fifo_count_out  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Interface: one clock, clk_in; reset rst_in is asynchronous and active-high.
- Reset values: pdm_out=0, pdm_step_out=0, underrun_out=0, fifo_count_out=0, sample_ready_out=1. Accumulator, counters and current sample are cleared; state=IDLE.
- FIFO handshake:
  - sample_ready_out = (count < FIFO_DEPTH), combinational from count only.
  - Push when sample_valid_in && sample_ready_out.
  - Pop happens only at an internal sample boundary.
  - Push and pop in the same cycle: count unchanged. When full, ready stays 0 even during a same-cycle pop.
  - Pop when empty never takes the word being pushed in that same cycle. The pushed word is stored and an underrun is raised.
  - FIFO accepts pushes in every state except during reset.
- Offset conversion: u = {~s[MSB], s[MSB-1:0]}. So 0x80→0x00, 0x00→0x80, 0x7F→0xFF.
- Accumulator: acc is SAMPLE_W bits. On each step, {carry, acc} <= acc + u; pdm_out <= carry; pdm_step_out=1 for that cycle only. The sum is SAMPLE_W+1 bits wide and acc wraps modulo 2^SAMPLE_W.
- State machine:
  - IDLE: step_cnt=samp_cnt=acc=0, pdm_out=0. If enable_in → PRIME.
  - PRIME: if FIFO non-empty → pop into cur_sample, counters=0, → RUN. If enable_in low → IDLE. Underrun is not flagged in PRIME.
  - RUN: step_cnt increments every cycle and wraps at STEP_PERIOD-1. The step occurs in the cycle where step_cnt==STEP_PERIOD-1, and pdm_out/pdm_step_out are registered on that edge. samp_cnt increments per step. At the step where samp_cnt==STEPS_PER_SAMPLE-1:
    - if FIFO is non-empty, pop into cur_sample;
    - otherwise load cur_sample=0 (midscale) and set underrun_out.
    - The new sample applies from the next step.
  - RUN with enable_in low → IDLE on the next edge. acc is cleared, pdm_out=0, FIFO contents are retained.
- First PDM step occurs STEP_PERIOD cycles after entering RUN.
- underrun_out: sticky until clear_underrun_in. If set and clear occur in the same cycle, set wins.
- fifo_count_out: registered, updated on the edge of each push/pop.
- Async reset mid-window: all outputs go to reset values immediately, without waiting for a clock edge. FIFO is emptied.

Optional Feature:
- PDM_DITHER_EN:
  - Defined: a 16-bit Galois LFSR (taps 0xB400, seed 0xACE1 on reset) advances once per step, and its bit 0 is added as carry-in to acc + u. This breaks idle tones; ones per 256-step window then vary by ±1 from u.
  - Undefined: no LFSR, carry-in is 0, and counts are exact.

Test Plan:
- Reset: assert rst_in mid-run with no clock edge → pdm_out=0, underrun_out=0, fifo_count_out=0, sample_ready_out=1 immediately.
- Midscale: push 0x00 ×4, enable → each 256-step window (8192 cycles) has exactly 128 pdm_out ones; pdm_step_out period is 32 cycles.
- Extremes: push 0x7F then 0x80 → first window 255 ones, second window 0 ones (dither off).
- Backpressure: disabled, push 9 samples with valid held → 8 accepted, ready=0, count=8. Enable → after first PRIME pop, count=7 and the 9th push is accepted.
- Underrun: push one sample 0x40, enable → at the first sample boundary underrun_out=1 and the next window has 128 ones. Pulse clear_underrun_in → 0 unless that same cycle is an underrun boundary.
- Enable drop: deassert enable_in mid-window with 3 queued → next edge IDLE, pdm_out=0, count stays 3. Re-enable → PRIME pops and the window restarts from acc=0.

Source files
------------

// File: rtl/audio_pdm_tx.sv
// audio_pdm_tx: playback-side PDM transmitter for the audio link.
//
// Buffers signed audio samples in a small FIFO (valid/ready push side) and
// turns the current sample into a 1-bit first-order sigma-delta stream. One
// PDM step is taken every STEP_PERIOD clocks. A new sample is taken from the
// FIFO every STEPS_PER_SAMPLE steps.
//
// Optional build macro: PDM_DITHER_EN. When it is defined, a 16-bit Galois
// LFSR supplies a carry-in to the accumulator to break up idle tones.
//
// Ports:
//   clk_in             system clock (clk_m domain)
//   rst_in             asynchronous, active-high reset
//   enable_in          run the modulator; low parks it in idle
//   sample_in          signed audio sample (two's complement)
//   sample_valid_in    sample_in is valid
//   sample_ready_out   FIFO can accept a sample this cycle
//   clear_underrun_in  clears the sticky underrun flag
//   pdm_out            PDM bit
//   pdm_step_out       one-cycle pulse on the cycle pdm_out updates
//   underrun_out       sticky: FIFO was empty at a sample boundary
//   fifo_count_out     FIFO occupancy
module audio_pdm_tx #(
  parameter int unsigned SAMPLE_W         = 8,
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned STEP_PERIOD      = 32,
  parameter int unsigned STEPS_PER_SAMPLE = 256
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid_in,
  output logic                          sample_ready_out,
  input  logic                          clear_underrun_in,
  output logic                          pdm_out,
  output logic                          pdm_step_out,
  output logic                          underrun_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned StepW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam int unsigned SampW = (STEPS_PER_SAMPLE > 1) ? $clog2(STEPS_PER_SAMPLE) : 1;

  localparam logic [StepW-1:0] StepLast = StepW'(STEP_PERIOD - 1);
  localparam logic [SampW-1:0] SampLast = SampW'(STEPS_PER_SAMPLE - 1);
  localparam logic [CntW-1:0]  DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun
  } state_e;

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [CntW-1:0]     count_d;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [SAMPLE_W-1:0] head;

  // ---------------------------------------------------------------------------
  // Modulator state
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic [StepW-1:0]    step_cnt_q;
  logic [SampW-1:0]    samp_cnt_q;
  logic [SAMPLE_W-1:0] acc_q;
  logic [SAMPLE_W-1:0] cur_q;
  logic [SAMPLE_W-1:0] cur_u;
  logic [SAMPLE_W:0]   sum;
  logic                carry_in;
  logic                at_step;
  logic                at_boundary;
  logic                prime_pop;
  logic                underrun_set;

  // Ready depends on the registered count only, so a full FIFO stays not-ready
  // even in a cycle where a pop is about to free an entry.
  assign sample_ready_out = (count_q < DepthCnt);
  assign fifo_count_out   = count_q;
  assign fifo_empty       = (count_q == '0);
  assign head             = mem_q[rd_ptr_q];

  assign push = sample_valid_in && sample_ready_out;

  assign at_step      = (state_q == StRun) && enable_in && (step_cnt_q == StepLast);
  assign at_boundary  = at_step && (samp_cnt_q == SampLast);
  assign prime_pop    = (state_q == StPrime) && enable_in && !fifo_empty;
  // Pops are gated by the registered count, so a word pushed in the same cycle
  // as a boundary on an empty FIFO is stored rather than consumed.
  assign pop          = prime_pop || (at_boundary && !fifo_empty);
  assign underrun_set = at_boundary && fifo_empty;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk_in) begin
    if (push && !rst_in) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sigma-delta datapath
  // ---------------------------------------------------------------------------
  // Signed sample to offset binary: flipping the sign bit maps the most
  // negative code to 0 and the most positive code to all-ones.
  assign cur_u = {~cur_q[SAMPLE_W-1], cur_q[SAMPLE_W-2:0]};
  assign sum   = {1'b0, acc_q} + {1'b0, cur_u} + (SAMPLE_W + 1)'(carry_in);

`ifdef PDM_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lfsr_q <= 16'hACE1;
    end else if (at_step) begin
      lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    end
  end

  assign carry_in = lfsr_q[0];
`else
  assign carry_in = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      step_cnt_q   <= '0;
      samp_cnt_q   <= '0;
      acc_q        <= '0;
      cur_q        <= '0;
      pdm_out      <= 1'b0;
      pdm_step_out <= 1'b0;
      underrun_out <= 1'b0;
    end else begin
      pdm_step_out <= 1'b0;

      // A set in the same cycle as a clear takes priority.
      if (underrun_set) begin
        underrun_out <= 1'b1;
      end else if (clear_underrun_in) begin
        underrun_out <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          step_cnt_q <= '0;
          samp_cnt_q <= '0;
          acc_q      <= '0;
          pdm_out    <= 1'b0;
          if (enable_in) begin
            state_q <= StPrime;
          end
        end

        StPrime: begin
          if (!enable_in) begin
            state_q <= StIdle;
          end else if (!fifo_empty) begin
            cur_q      <= head;
            step_cnt_q <= '0;
            samp_cnt_q <= '0;
            state_q    <= StRun;
          end
        end

        StRun: begin
          if (!enable_in) begin
            state_q    <= StIdle;
            step_cnt_q <= '0;
            samp_cnt_q <= '0;
            acc_q      <= '0;
            pdm_out    <= 1'b0;
          end else if (step_cnt_q == StepLast) begin
            step_cnt_q   <= '0;
            acc_q        <= sum[SAMPLE_W-1:0];
            pdm_out      <= sum[SAMPLE_W];
            pdm_step_out <= 1'b1;
            if (samp_cnt_q == SampLast) begin
              samp_cnt_q <= '0;
              // The boundary step still used the old sample; the new one
              // (or midscale on underrun) applies from the next step.
              cur_q      <= fifo_empty ? '0 : head;
            end else begin
              samp_cnt_q <= samp_cnt_q + SampW'(1);
            end
          end else begin
            step_cnt_q <= step_cnt_q + StepW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_pdm_tx.sv
module tb_audio_pdm_tx;

  localparam int SP  = 32;
  localparam int SPS = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] sample = 8'h00;
  logic       sample_valid = 1'b0;
  logic       clear_underrun = 1'b0;
  logic       ready;
  logic       pdm;
  logic       pdm_step;
  logic       underrun;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  audio_pdm_tx #(
    .SAMPLE_W        (8),
    .FIFO_DEPTH      (8),
    .STEP_PERIOD     (SP),
    .STEPS_PER_SAMPLE(SPS)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .enable_in        (enable),
    .sample_in        (sample),
    .sample_valid_in  (sample_valid),
    .sample_ready_out (ready),
    .clear_underrun_in(clear_underrun),
    .pdm_out          (pdm),
    .pdm_step_out     (pdm_step),
    .underrun_out     (underrun),
    .fifo_count_out   (count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits for the next pdm_step pulse (sampled on negedges); gap = negedges waited.
  task automatic wait_step(output logic bit_o, output int gap);
    logic found;
    found = 1'b0;
    bit_o = 1'b0;
    gap   = 0;
    for (int i = 0; i < 4 * SP && !found; i++) begin
      @(negedge clk);
      gap++;
      if (pdm_step) begin
        found = 1'b1;
        bit_o = pdm;
      end
    end
    if (!found) check_eq("step_timeout", pdm_step, 1'b1);
  endtask

  task automatic run_window(input int nsteps, output int ones, output int bad_gaps);
    logic b;
    int   g;
    ones     = 0;
    bad_gaps = 0;
    for (int k = 0; k < nsteps; k++) begin
      wait_step(b, g);
      ones += int'(b);
      if (g != SP) bad_gaps++;
    end
  endtask

  task automatic push(input logic [7:0] v);
    @(negedge clk);
    sample       = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic b, b1, b2, b3, b4;
    int   g, ones, ones2, bad, pulses;

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_pdm", pdm, 1'b0);
    check_eq("rst_step", pdm_step, 1'b0);
    check_eq("rst_underrun", underrun, 1'b0);
    check_eq("rst_count", count, 0);
    check_eq("rst_ready", ready, 1'b1);

    // Backpressure: valid held for 9 cycles while disabled -> 8 accepted
    @(negedge clk);
    sample       = 8'h00;
    sample_valid = 1'b1;
    repeat (9) @(negedge clk);
    check_eq("bp_count_full", count, 8);
    check_eq("bp_ready_full", ready, 1'b0);
    enable = 1'b1;
    @(negedge clk);                       // IDLE -> PRIME
    @(negedge clk);                       // PRIME pops, enters RUN
    check_eq("bp_count_after_pop", count, 7);
    check_eq("bp_ready_after_pop", ready, 1'b1);
    @(negedge clk);                       // held 9th sample accepted
    check_eq("bp_count_refill", count, 8);
    sample_valid = 1'b0;

    // Midscale: first step lands 32 clocks after RUN entry, i.e. 31 negedges from here
    wait_step(b, g);
    check_eq("first_step_latency", g, 31);
    run_window(SPS - 1, ones, bad);
    check_eq("mid_win1_ones", ones + int'(b), 128);
    check_eq("mid_win1_period", bad, 0);
    run_window(SPS, ones, bad);
    check_eq("mid_win2_ones", ones, 128);
    check_eq("mid_win2_period", bad, 0);
    check_eq("mid_count_after_2_pops", count, 6);

    // Extremes: 0x7F -> 255 ones, then 0x80 -> 0 ones
    do_reset();
    push(8'h7F);
    push(8'h80);
    check_eq("ext_count", count, 2);
    enable = 1'b1;
    run_window(SPS, ones, bad);
    check_eq("ext_max_ones", ones, 255);
    check_eq("ext_no_underrun_w1", underrun, 1'b0);
    run_window(SPS, ones, bad);
    check_eq("ext_min_ones", ones, 0);
    check_eq("ext_underrun_w2", underrun, 1'b1);

    // Underrun: PRIME on an empty FIFO waits without flagging
    do_reset();
    enable = 1'b1;
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      if (pdm_step) pulses++;
    end
    check_eq("prime_no_steps", pulses, 0);
    check_eq("prime_no_underrun", underrun, 1'b0);
    push(8'h40);
    run_window(SPS - 1, ones, bad);
    check_eq("ur_before_boundary", underrun, 1'b0);
    wait_step(b, g);
    check_eq("ur_win1_ones", ones + int'(b), 192);
    check_eq("ur_set_at_boundary", underrun, 1'b1);
    ones2 = 0;
    for (int k = 1; k <= SPS; k++) begin
      if (k == SPS) begin
        repeat (SP - 1) @(negedge clk);   // now inside the boundary cycle
        clear_underrun = 1'b1;
      end
      wait_step(b, g);
      ones2 += int'(b);
      if (k == SPS) clear_underrun = 1'b0;
      if (k == 10) begin
        check_eq("ur_still_set", underrun, 1'b1);
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        check_eq("ur_cleared", underrun, 1'b0);
      end
    end
    check_eq("ur_win2_midscale_ones", ones2, 128);
    check_eq("ur_set_wins_over_clear", underrun, 1'b1);
    @(negedge clk);
    check_eq("ur_sticky", underrun, 1'b1);

    // Asynchronous reset mid-run, checked before any clock edge
    push(8'h11);
    check_eq("pre_rst_count", count, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_pdm", pdm, 1'b0);
    check_eq("arst_step", pdm_step, 1'b0);
    check_eq("arst_underrun", underrun, 1'b0);
    check_eq("arst_count", count, 0);
    check_eq("arst_ready", ready, 1'b1);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Enable drop with 3 queued, then restart from acc=0
    push(8'h40);
    push(8'h40);
    push(8'h40);
    push(8'h40);
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("drop_count_queued", count, 3);
    for (int k = 0; k < 42; k++) wait_step(b, g);
    // u=0xC0 from acc=0 gives the repeating pattern 0,1,1,1; step 42 is a 1
    check_eq("drop_pdm_before", pdm, 1'b1);
    enable = 1'b0;
    @(negedge clk);
    check_eq("drop_pdm_idle", pdm, 1'b0);
    check_eq("drop_step_idle", pdm_step, 1'b0);
    check_eq("drop_count_kept", count, 3);
    repeat (3) @(negedge clk);
    check_eq("drop_count_still", count, 3);
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("reen_prime_pop", count, 2);
    wait_step(b1, g);
    wait_step(b2, g);
    wait_step(b3, g);
    wait_step(b4, g);
    check_eq("reen_acc_restart_bits", {28'd0, b1, b2, b3, b4}, 32'b0111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
